// File: rtl/uart_vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_vga_pkg
//  Description : Shared constants and types for the UART-to-VGA text path
//                (terminal control codes, printable range, writer states).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_vga_pkg;

    // Terminal control codes understood by the text writer
    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_SPACE = 8'h20;

    // Inclusive bounds of the printable character range
    localparam logic [7:0] CHR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

    // Default screen geometry
    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 30;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_CLEAR_LINE = 2'd1,
        S_CLEAR_ALL  = 2'd2
    } writer_state_t;

endpackage : uart_vga_pkg
`default_nettype wire

// File: rtl/uart_text_writer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_text_writer
//  Description : Turns the UART byte stream into writes to a COLS x ROWS text
//                buffer: cursor tracking, CR/LF/BS/FF, line wrap and scrolling
//                through a circular row base with bottom-line clearing.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_text_writer
    import uart_vga_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = $clog2(COLS*ROWS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      drdy,
    input  logic [7:0]                data,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [7:0]                wr_data,
    output logic [$clog2(ROWS)-1:0]   row_base,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic                      busy,
    output logic                      overflow
);

    localparam int c_col_w = $clog2(COLS);
    localparam int c_row_w = $clog2(ROWS);
    localparam int c_cells = COLS * ROWS;

    // Modular row addition without a divider: operands are already < ROWS,
    // so a single conditional subtract is enough.
    function automatic logic [c_row_w-1:0] row_add(input logic [c_row_w-1:0] a,
                                                   input logic [c_row_w-1:0] b);
        logic [c_row_w:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (c_row_w+1)'(ROWS))
            s = s - (c_row_w+1)'(ROWS);
        return s[c_row_w-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [c_row_w-1:0] row,
                                                  input logic [ADDR_W-1:0]  col);
        return ADDR_W'(row) * ADDR_W'(COLS) + col;
    endfunction

    logic                 r_in_v;
    logic [7:0]           r_in_data;
    logic                 r_pend_v;
    logic [7:0]           r_pend;
    writer_state_t        r_state,      w_state_nx;
    logic [ADDR_W-1:0]    r_clr_cnt,    w_clr_cnt_nx;
    logic [c_row_w-1:0]   r_clr_line,   w_clr_line_nx;
    logic                 r_wr_en,      w_wr_en_nx;
    logic [ADDR_W-1:0]    r_wr_addr,    w_wr_addr_nx;
    logic [7:0]           r_wr_data,    w_wr_data_nx;
    logic [c_row_w-1:0]   r_row_base,   w_row_base_nx;
    logic [c_col_w-1:0]   r_cursor_col, w_cursor_col_nx;
    logic [c_row_w-1:0]   r_cursor_row, w_cursor_row_nx;
    logic                 r_busy,       w_busy_nx;
    logic                 r_overflow;
    logic                 w_consume;
    logic                 w_newline;
    logic [c_row_w-1:0]   w_phys_row;
    logic [c_col_w-1:0]   w_col_m1;

    assign w_phys_row = row_add(r_row_base, r_cursor_row);
    assign w_col_m1   = r_cursor_col - c_col_w'(1);

    // Input sampling stage: decouples the UART strobe from the pending slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_v    <= 1'b0;
            r_in_data <= 8'h00;
        end else begin
            r_in_v    <= drdy;
            r_in_data <= data;
        end
    end

    // One-entry pending slot; a byte arriving into a full, unconsumed slot is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_v   <= 1'b0;
            r_pend     <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (r_in_v && (!r_pend_v || w_consume)) begin
                r_pend   <= r_in_data;
                r_pend_v <= 1'b1;
            end else begin
                if (w_consume)
                    r_pend_v <= 1'b0;
                if (r_in_v)
                    r_overflow <= 1'b1;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_CLEAR_ALL;
            r_clr_cnt    <= '0;
            r_clr_line   <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= CHR_SPACE;
            r_row_base   <= '0;
            r_cursor_col <= '0;
            r_cursor_row <= '0;
            r_busy       <= 1'b1;
        end else begin
            r_state      <= w_state_nx;
            r_clr_cnt    <= w_clr_cnt_nx;
            r_clr_line   <= w_clr_line_nx;
            r_wr_en      <= w_wr_en_nx;
            r_wr_addr    <= w_wr_addr_nx;
            r_wr_data    <= w_wr_data_nx;
            r_row_base   <= w_row_base_nx;
            r_cursor_col <= w_cursor_col_nx;
            r_cursor_row <= w_cursor_row_nx;
            r_busy       <= w_busy_nx;
        end
    end

    // Next-state, character decode, cursor movement and clear sequencing
    always_comb begin
        w_state_nx      = r_state;
        w_clr_cnt_nx    = r_clr_cnt;
        w_clr_line_nx   = r_clr_line;
        w_wr_en_nx      = 1'b0;
        w_wr_addr_nx    = r_wr_addr;
        w_wr_data_nx    = r_wr_data;
        w_row_base_nx   = r_row_base;
        w_cursor_col_nx = r_cursor_col;
        w_cursor_row_nx = r_cursor_row;
        w_consume       = 1'b0;
        w_newline       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_pend_v) begin
                    w_consume = 1'b1;
                    if (r_pend >= CHR_PRINT_LO && r_pend <= CHR_PRINT_HI) begin
                        w_wr_en_nx   = 1'b1;
                        w_wr_addr_nx = addr_of(w_phys_row, ADDR_W'(r_cursor_col));
                        w_wr_data_nx = r_pend;
                        if (r_cursor_col == c_col_w'(COLS-1)) begin
                            w_cursor_col_nx = '0;
                            w_newline       = 1'b1;
                        end else begin
                            w_cursor_col_nx = r_cursor_col + c_col_w'(1);
                        end
                    end else begin
                        case (r_pend)
                            CHR_CR: w_cursor_col_nx = '0;
                            CHR_LF: begin
                                w_cursor_col_nx = '0;
                                w_newline       = 1'b1;
                            end
                            CHR_BS: begin
                                if (r_cursor_col != '0) begin
                                    w_cursor_col_nx = w_col_m1;
                                    w_wr_en_nx      = 1'b1;
                                    w_wr_addr_nx    = addr_of(w_phys_row, ADDR_W'(w_col_m1));
                                    w_wr_data_nx    = CHR_SPACE;
                                end
                            end
                            CHR_FF: begin
                                w_state_nx   = S_CLEAR_ALL;
                                w_clr_cnt_nx = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_CLEAR_LINE: begin
                w_wr_en_nx   = 1'b1;
                w_wr_addr_nx = addr_of(r_clr_line, r_clr_cnt);
                w_wr_data_nx = CHR_SPACE;
                if (r_clr_cnt == ADDR_W'(COLS-1)) begin
                    w_clr_cnt_nx = '0;
                    w_state_nx   = S_IDLE;
                end else begin
                    w_clr_cnt_nx = r_clr_cnt + ADDR_W'(1);
                end
            end
            S_CLEAR_ALL: begin
                w_wr_en_nx   = 1'b1;
                w_wr_addr_nx = r_clr_cnt;
                w_wr_data_nx = CHR_SPACE;
                if (r_clr_cnt == ADDR_W'(c_cells-1)) begin
                    w_clr_cnt_nx    = '0;
                    w_row_base_nx   = '0;
                    w_cursor_col_nx = '0;
                    w_cursor_row_nx = '0;
                    w_state_nx      = S_IDLE;
                end else begin
                    w_clr_cnt_nx = r_clr_cnt + ADDR_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // Newline: move down, or scroll by advancing the base and blanking
        // the physical row that becomes the new bottom line.
        if (w_newline) begin
            if (r_cursor_row != c_row_w'(ROWS-1)) begin
                w_cursor_row_nx = r_cursor_row + c_row_w'(1);
            end else begin
                w_row_base_nx = row_add(r_row_base, c_row_w'(1));
                w_clr_line_nx = r_row_base;
                w_clr_cnt_nx  = '0;
                w_state_nx    = S_CLEAR_LINE;
            end
        end

        // Busy covers every cycle that presents a clear write
        w_busy_nx = (r_state != S_IDLE) || (w_state_nx != S_IDLE);
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign row_base   = r_row_base;
    assign cursor_col = r_cursor_col;
    assign cursor_row = r_cursor_row;
    assign busy       = r_busy;
    assign overflow   = r_overflow;

endmodule : uart_text_writer
`default_nettype wire

// File: tb/tb_uart_text_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_text_writer
//  Description : Self-checking bench for uart_text_writer on a 4x3 screen:
//                directed vectors, scroll/overflow/reset corner sequences and
//                random byte streams against a screen-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_text_writer;
    import uart_vga_pkg::*;

    localparam int COLS  = 4;
    localparam int ROWS  = 3;
    localparam int AW    = $clog2(COLS*ROWS);
    localparam int CELLS = COLS * ROWS;

    logic          clk;
    logic          rst_n;
    logic          drdy;
    logic [7:0]    data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [1:0]    row_base;
    logic [1:0]    cursor_col;
    logic [1:0]    cursor_row;
    logic          busy;
    logic          overflow;

    uart_text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .drdy       (drdy),
        .data       (data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .row_base   (row_base),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    // ---------------- write monitor (what the buffer would hold) -----------
    logic [7:0] dut_mem [CELLS];
    int         wr_cnt  = 0;
    int         ovf_cnt = 0;
    logic [7:0] wlog [$];

    always @(negedge clk) begin
        if (wr_en) begin
            chk("wr_addr_in_range", (int'(wr_addr) < CELLS) ? 32'd1 : 32'd0, 32'd1);
            if (int'(wr_addr) < CELLS) dut_mem[wr_addr] = wr_data;
            wr_cnt++;
            wlog.push_back(wr_data);
        end
        if (overflow) ovf_cnt++;
    end

    // ---------------- screen-level reference model -------------------------
    logic [7:0] m_mem [CELLS];
    int m_col, m_row, m_base;

    function automatic void model_reset();
        for (int i = 0; i < CELLS; i++) m_mem[i] = 8'h20;
        m_col = 0; m_row = 0; m_base = 0;
    endfunction

    function automatic int model_newline();
        if (m_row < ROWS-1) begin
            m_row++;
            return 0;
        end
        for (int c = 0; c < COLS; c++) m_mem[m_base*COLS + c] = 8'h20;
        m_base = (m_base + 1) % ROWS;
        return COLS;
    endfunction

    // Applies one byte; returns the number of buffer writes it must cause
    function automatic int model_byte(input logic [7:0] b);
        int n;
        int phys;
        n    = 0;
        phys = (m_base + m_row) % ROWS;
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_mem[phys*COLS + m_col] = b;
            n = 1;
            if (m_col == COLS-1) begin
                m_col = 0;
                n += model_newline();
            end else m_col++;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_col = 0;
            n = model_newline();
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_mem[phys*COLS + m_col] = 8'h20;
                n = 1;
            end
        end else if (b == 8'h0C) begin
            model_reset();
            n = CELLS;
        end
        return n;
    endfunction

    task automatic verify_model(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_cursor_col"}, 32'(cursor_col), 32'(m_col));
        chk({tag, "_cursor_row"}, 32'(cursor_row), 32'(m_row));
        chk({tag, "_row_base"},   32'(row_base),   32'(m_base));
        for (int i = 0; i < CELLS; i++) if (dut_mem[i] !== m_mem[i]) bad++;
        chk({tag, "_cells_wrong"}, 32'(bad), 32'd0);
    endtask

    // ---------------- stimulus helpers (called at a falling edge) ----------
    task automatic drive(input logic [7:0] b);
        drdy = 1'b1;
        data = b;
        @(negedge clk);
        drdy = 1'b0;
        data = 8'h00;
    endtask

    task automatic wait_quiet();
        int q, budget;
        q = 0; budget = 0;
        while (q < 4 && budget < 400) begin
            @(negedge clk);
            budget++;
            if (!busy && !wr_en) q++; else q = 0;
        end
        if (q < 4) fail_now("wait_quiet");
    endtask

    task automatic send(input logic [7:0] b);
        void'(model_byte(b));
        drive(b);
        wait_quiet();
    endtask

    // Expects a full-screen clear starting on the next falling edge
    task automatic check_full_clear(input string tag);
        for (int i = 0; i < CELLS; i++) begin
            @(negedge clk);
            chk({tag, "_clr_we"},   32'(wr_en),   32'd1);
            chk({tag, "_clr_addr"}, 32'(wr_addr), 32'(i));
            chk({tag, "_clr_data"}, 32'(wr_data), 32'h20);
        end
        @(negedge clk);
        chk({tag, "_done_busy"}, 32'(busy),       32'd0);
        chk({tag, "_done_we"},   32'(wr_en),      32'd0);
        chk({tag, "_done_col"},  32'(cursor_col), 32'd0);
        chk({tag, "_done_row"},  32'(cursor_row), 32'd0);
        chk({tag, "_done_base"}, 32'(row_base),   32'd0);
    endtask

    typedef struct {
        logic [7:0]    b;
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic [1:0]    col;
        logic [1:0]    row;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget, ovf0, nx, ny, c0, ex, r;
        logic [7:0] b;

        vecs[0] = '{8'h41, 1'b1, 4'd0, 8'h41, 2'd1, 2'd0};
        vecs[1] = '{8'h42, 1'b1, 4'd1, 8'h42, 2'd2, 2'd0};
        vecs[2] = '{8'h08, 1'b1, 4'd1, 8'h20, 2'd1, 2'd0};
        vecs[3] = '{8'h0D, 1'b0, 4'd0, 8'h00, 2'd0, 2'd0};
        vecs[4] = '{8'h08, 1'b0, 4'd0, 8'h00, 2'd0, 2'd0};
        vecs[5] = '{8'h0A, 1'b0, 4'd0, 8'h00, 2'd0, 2'd1};
        vecs[6] = '{8'h43, 1'b1, 4'd4, 8'h43, 2'd1, 2'd1};

        drdy = 1'b0; data = 8'h00; rst_n = 1'b0;
        for (int i = 0; i < CELLS; i++) dut_mem[i] = 8'h00;
        model_reset();

        // Reset values, then the power-up clear
        repeat (3) @(negedge clk);
        chk("rst_wr_en",    32'(wr_en),      32'd0);
        chk("rst_wr_addr",  32'(wr_addr),    32'd0);
        chk("rst_wr_data",  32'(wr_data),    32'h20);
        chk("rst_row_base", 32'(row_base),   32'd0);
        chk("rst_col",      32'(cursor_col), 32'd0);
        chk("rst_row",      32'(cursor_row), 32'd0);
        chk("rst_busy",     32'(busy),       32'd1);
        chk("rst_overflow", 32'(overflow),   32'd0);
        rst_n = 1'b1;
        check_full_clear("por");

        // Directed vectors: two-edge latency, write contents, cursor moves
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].b);
            @(negedge clk);
            chk("vec_no_early_write", 32'(wr_en), 32'd0);
            @(negedge clk);
            chk("vec_we", 32'(wr_en), 32'(vecs[i].we));
            if (vecs[i].we) begin
                chk("vec_addr", 32'(wr_addr), 32'(vecs[i].addr));
                chk("vec_data", 32'(wr_data), 32'(vecs[i].wdata));
            end
            chk("vec_col", 32'(cursor_col), 32'(vecs[i].col));
            chk("vec_row", 32'(cursor_row), 32'(vecs[i].row));
            void'(model_byte(vecs[i].b));
            wait_quiet();
        end
        verify_model("vec");

        // Fill the screen: the 12th character writes first, then row 0 is blanked
        send(CHR_FF);
        for (int i = 0; i < 11; i++) send(8'(8'h61 + i));
        void'(model_byte(8'h6C));
        drive(8'h6C);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_last_we",   32'(wr_en),   32'd1);
        chk("wrap_last_addr", 32'(wr_addr), 32'd11);
        chk("wrap_last_data", 32'(wr_data), 32'h6C);
        for (int c = 0; c < COLS; c++) begin
            @(negedge clk);
            chk("scroll_clr_we",   32'(wr_en),   32'd1);
            chk("scroll_clr_addr", 32'(wr_addr), 32'(c));
            chk("scroll_clr_data", 32'(wr_data), 32'h20);
        end
        wait_quiet();
        chk("scroll_row_base", 32'(row_base),   32'd1);
        chk("scroll_row",      32'(cursor_row), 32'd2);
        chk("scroll_col",      32'(cursor_col), 32'd0);
        verify_model("scroll");

        // Overflow: two bytes one cycle apart while clearing
        ovf0 = ovf_cnt;
        void'(model_byte(CHR_FF));
        drive(CHR_FF);
        budget = 0;
        while (!busy && budget < 20) begin @(negedge clk); budget++; end
        if (!busy) fail_now("ovf_wait_busy");
        wlog.delete();
        void'(model_byte(8'h58));
        drive(8'h58);
        @(negedge clk);
        drive(8'h59);
        wait_quiet();
        chk("ovf_pulses", 32'(ovf_cnt - ovf0), 32'd1);
        nx = 0; ny = 0;
        foreach (wlog[i]) begin
            if (wlog[i] == 8'h58) nx++;
            if (wlog[i] == 8'h59) ny++;
        end
        chk("ovf_first_written",  32'(nx), 32'd1);
        chk("ovf_second_dropped", 32'(ny), 32'd0);
        verify_model("ovf");

        // Random byte streams against the reference model
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      b = 8'($urandom_range(32, 126));
            else if (r < 68) b = CHR_CR;
            else if (r < 78) b = CHR_LF;
            else if (r < 90) b = CHR_BS;
            else if (r < 93) b = CHR_FF;
            else begin
                b = 8'($urandom_range(0, 255));
                if ((b >= 8'h20 && b <= 8'h7E) || b == CHR_CR || b == CHR_LF ||
                    b == CHR_BS || b == CHR_FF) b = 8'h1B;
            end
            c0 = wr_cnt;
            ex = model_byte(b);
            drive(b);
            wait_quiet();
            chk("rand_write_count", 32'(wr_cnt - c0), 32'(ex));
            verify_model("rand");
        end

        // Reset on the 5th cycle of a form-feed clear restarts it from address 0
        drive(CHR_FF);
        budget = 0;
        while (!(wr_en && busy && wr_addr == '0) && budget < 30) begin
            @(negedge clk); budget++;
        end
        if (!(wr_en && busy && wr_addr == '0)) fail_now("ff_clear_start");
        repeat (4) @(negedge clk);
        chk("mid_clear_5th_we",   32'(wr_en),   32'd1);
        chk("mid_clear_5th_addr", 32'(wr_addr), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("async_rst_we",   32'(wr_en),   32'd0);
        chk("async_rst_busy", 32'(busy),    32'd1);
        chk("async_rst_addr", 32'(wr_addr), 32'd0);
        chk("async_rst_data", 32'(wr_data), 32'h20);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_full_clear("restart");
        verify_model("restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_uart_text_writer
`default_nettype wire
